// File: rtl/branch_predictor_banked_ram.sv
// Multi-way branch predictor storage: C_WAYS simple-dual-port RAM banks with a shared
// read/write address, per-way write enables, a post-reset init sweep and optional write bypass.
module branch_predictor_banked_ram #(
    parameter int                       C_DATA_WIDTH = 20,
    parameter int                       C_DEPTH      = 512,
    parameter int                       C_WAYS       = 2,
    parameter logic [C_DATA_WIDTH-1:0]  C_INIT_VALUE = '0,
    parameter bit                       C_BYPASS     = 1'b1,
    localparam int                      C_ADDR_W     = $clog2(C_DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [C_ADDR_W-1:0]            read_addr,
    input  logic                           read_en,
    output logic [C_WAYS*C_DATA_WIDTH-1:0] read_data,
    output logic                           read_valid,
    input  logic [C_ADDR_W-1:0]            write_addr,
    input  logic [C_WAYS-1:0]              write_en,
    input  logic [C_WAYS*C_DATA_WIDTH-1:0] write_data,
    output logic                           init_done
);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                         state_q, state_d;
    logic [C_ADDR_W-1:0]            init_count_q, init_count_d;
    logic [C_WAYS*C_DATA_WIDTH-1:0] read_data_q, read_data_d;
    logic                           read_valid_q, read_valid_d;

    logic [C_WAYS-1:0]              mem_we;
    logic [C_ADDR_W-1:0]            mem_waddr;
    logic [C_WAYS*C_DATA_WIDTH-1:0] mem_wdata;
    logic [C_DATA_WIDTH-1:0]        bank_rdata [C_WAYS];

    // One bank per way; no reset on the arrays so each maps onto a block RAM.
    for (genvar w = 0; w < C_WAYS; w++) begin : g_bank
        logic [C_DATA_WIDTH-1:0] bank [C_DEPTH];

        always_ff @(posedge clk) begin
            if (mem_we[w]) begin
                bank[mem_waddr] <= mem_wdata[w*C_DATA_WIDTH +: C_DATA_WIDTH];
            end
        end

        assign bank_rdata[w] = bank[read_addr];
    end

    always_comb begin
        state_d      = state_q;
        init_count_d = init_count_q;
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;
        mem_we       = '0;
        mem_waddr    = write_addr;
        mem_wdata    = write_data;

        case (state_q)
            ST_INIT: begin
                // The sweep owns the write port; external requests are dropped.
                mem_we    = '1;
                mem_waddr = init_count_q;
                mem_wdata = {C_WAYS{C_INIT_VALUE}};
                if (init_count_q == C_ADDR_W'(C_DEPTH - 1)) begin
                    state_d = ST_READY;
                end else begin
                    init_count_d = init_count_q + C_ADDR_W'(1);
                end
            end
            ST_READY: begin
                mem_we = write_en;
                if (read_en) begin
                    read_valid_d = 1'b1;
                    for (int w = 0; w < C_WAYS; w++) begin
                        if (C_BYPASS && write_en[w] && (read_addr == write_addr)) begin
                            read_data_d[w*C_DATA_WIDTH +: C_DATA_WIDTH] =
                                write_data[w*C_DATA_WIDTH +: C_DATA_WIDTH];
                        end else begin
                            read_data_d[w*C_DATA_WIDTH +: C_DATA_WIDTH] = bank_rdata[w];
                        end
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_INIT;
            init_count_q <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_count_q <= init_count_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
        end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
    assign init_done  = (state_q == ST_READY);

endmodule

// File: tb/tb_branch_predictor_banked_ram.sv
// Self-checking bench for branch_predictor_banked_ram: init sweep timing, INIT gating,
// per-way writes, bypass, hold behaviour and reset in the middle of a sweep.
module tb_branch_predictor_banked_ram;

    localparam int DW = 20;
    localparam int WAYS = 2;
    localparam int DEPTH = 512;
    localparam int AW = 9;
    localparam int BW = WAYS * DW;

    logic          clk;
    logic          rst;
    logic [AW-1:0] read_addr;
    logic          read_en;
    logic [BW-1:0] read_data;
    logic          read_valid;
    logic [AW-1:0] write_addr;
    logic [WAYS-1:0] write_en;
    logic [BW-1:0] write_data;
    logic          init_done;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic          rd_en;
        logic [AW-1:0] rd_addr;
        logic [1:0]    wr_en;
        logic [AW-1:0] wr_addr;
        logic [BW-1:0] wr_data;
        logic          exp_valid;
        logic [BW-1:0] exp_data;
    } vec_t;

    typedef struct {
        logic          valid;
        logic [BW-1:0] data;
        string         name;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[19];

    branch_predictor_banked_ram #(
        .C_DATA_WIDTH(DW),
        .C_DEPTH(DEPTH),
        .C_WAYS(WAYS),
        .C_INIT_VALUE('0),
        .C_BYPASS(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .read_addr(read_addr),
        .read_en(read_en),
        .read_data(read_data),
        .read_valid(read_valid),
        .write_addr(write_addr),
        .write_en(write_en),
        .write_data(write_data),
        .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected result, then compare after the edge.
    task automatic applyStimulus(input vec_t v, input string name);
        exp_t e;
        exp_t got;
        read_en    = v.rd_en;
        read_addr  = v.rd_addr;
        write_en   = v.wr_en;
        write_addr = v.wr_addr;
        write_data = v.wr_data;
        e.valid = v.exp_valid;
        e.data  = v.exp_data;
        e.name  = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        checkOutput(got.name, 64'({read_valid, read_data}), 64'({got.valid, got.data}));
        read_en  = 1'b0;
        write_en = '0;
    endtask

    // Counts edges from reset release until init_done, bounded; also counts INIT-gating violations.
    task automatic waitInit(output int edges, output int bad);
        edges = 0;
        bad = 0;
        while (edges < 2000) begin
            @(posedge clk);
            edges++;
            #1;
            if (read_valid !== 1'b0) bad++;
            if (read_data !== '0) bad++;
            if (init_done === 1'b1) break;
        end
    endtask

    initial begin
        int edges;
        int bad;
        vec_t v;

        vecs = '{
            '{1'b1, 9'd0,   2'b00, 9'd0,   {20'h00000, 20'h00000}, 1'b1, {20'h00000, 20'h00000}},
            '{1'b1, 9'd1,   2'b00, 9'd0,   {20'h00000, 20'h00000}, 1'b1, {20'h00000, 20'h00000}},
            '{1'b1, 9'd255, 2'b00, 9'd0,   {20'h00000, 20'h00000}, 1'b1, {20'h00000, 20'h00000}},
            '{1'b1, 9'd511, 2'b00, 9'd0,   {20'h00000, 20'h00000}, 1'b1, {20'h00000, 20'h00000}},
            '{1'b1, 9'd3,   2'b00, 9'd0,   {20'h00000, 20'h00000}, 1'b1, {20'h00000, 20'h00000}},
            '{1'b0, 9'd0,   2'b01, 9'd5,   {20'h11111, 20'hABCDE}, 1'b0, {20'h00000, 20'h00000}},
            '{1'b1, 9'd5,   2'b00, 9'd0,   {20'h00000, 20'h00000}, 1'b1, {20'h00000, 20'hABCDE}},
            '{1'b1, 9'd9,   2'b11, 9'd9,   {20'h22222, 20'h33333}, 1'b1, {20'h22222, 20'h33333}},
            '{1'b1, 9'd9,   2'b00, 9'd0,   {20'h00000, 20'h00000}, 1'b1, {20'h22222, 20'h33333}},
            '{1'b1, 9'd7,   2'b10, 9'd7,   {20'h44444, 20'h55555}, 1'b1, {20'h44444, 20'h00000}},
            '{1'b1, 9'd7,   2'b00, 9'd0,   {20'h00000, 20'h00000}, 1'b1, {20'h44444, 20'h00000}},
            '{1'b1, 9'd21,  2'b01, 9'd20,  {20'h12345, 20'h66666}, 1'b1, {20'h00000, 20'h00000}},
            '{1'b1, 9'd20,  2'b00, 9'd0,   {20'h00000, 20'h00000}, 1'b1, {20'h00000, 20'h66666}},
            '{1'b1, 9'd0,   2'b11, 9'd511, {20'h77777, 20'h88888}, 1'b1, {20'h00000, 20'h00000}},
            '{1'b1, 9'd511, 2'b00, 9'd0,   {20'h00000, 20'h00000}, 1'b1, {20'h77777, 20'h88888}},
            '{1'b1, 9'd300, 2'b11, 9'd50,  {20'hAAAAA, 20'hBBBBB}, 1'b1, {20'h00000, 20'h00000}},
            '{1'b0, 9'd0,   2'b11, 9'd300, {20'hCCCCC, 20'hDDDDD}, 1'b0, {20'h00000, 20'h00000}},
            '{1'b1, 9'd50,  2'b00, 9'd0,   {20'h00000, 20'h00000}, 1'b1, {20'hAAAAA, 20'hBBBBB}},
            '{1'b1, 9'd300, 2'b00, 9'd0,   {20'h00000, 20'h00000}, 1'b1, {20'hCCCCC, 20'hDDDDD}}
        };

        rst = 1'b0;
        read_en = 1'b0;
        read_addr = '0;
        write_en = '0;
        write_addr = '0;
        write_data = '0;

        #3;
        checkOutput("reset_state", 64'({init_done, read_valid, read_data}), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // External traffic during the sweep must be ignored.
        read_en = 1'b1;
        read_addr = 9'd3;
        write_en = 2'b11;
        write_addr = 9'd3;
        write_data = {20'hFFFFF, 20'hFFFFF};
        waitInit(edges, bad);
        read_en = 1'b0;
        write_en = '0;
        checkOutput("init_edges", 64'(edges), 64'(DEPTH));
        checkOutput("init_gating", 64'(bad), 64'd0);

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Hold: reads disabled while addr 5 is rewritten.
        v = '{1'b1, 9'd5, 2'b00, 9'd0, '0, 1'b1, {20'h00000, 20'hABCDE}};
        applyStimulus(v, "hold_prime");
        for (int i = 0; i < 10; i++) begin
            v = '{1'b0, 9'd5, 2'b11, 9'd5, {20'(i + 1), 20'(i + 100)}, 1'b0, {20'h00000, 20'hABCDE}};
            applyStimulus(v, $sformatf("hold%0d", i));
        end
        v = '{1'b1, 9'd5, 2'b00, 9'd0, '0, 1'b1, {20'd10, 20'd109}};
        applyStimulus(v, "hold_after");

        // Async reset clears outputs without waiting for a clock edge.
        rst = 1'b0;
        #1;
        checkOutput("async_reset", 64'({init_done, read_valid, read_data}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        checkOutput("mid_sweep_busy", 64'(init_done), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("mid_sweep_reset", 64'({init_done, read_valid, read_data}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        waitInit(edges, bad);
        checkOutput("restart_edges", 64'(edges), 64'(DEPTH));

        v = '{1'b1, 9'd0, 2'b00, 9'd0, '0, 1'b1, '0};
        applyStimulus(v, "restart_rd0");
        v.rd_addr = 9'd50;
        applyStimulus(v, "restart_rd50");
        v.rd_addr = 9'd99;
        applyStimulus(v, "restart_rd99");
        v.rd_addr = 9'd300;
        applyStimulus(v, "restart_rd300");
        v.rd_addr = 9'd511;
        applyStimulus(v, "restart_rd511");
        v.rd_addr = 9'd5;
        applyStimulus(v, "restart_rd5");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
